barcode_word_assembler: RTL

Downstream stage of the barcode reader FSM. Consumes the 2-bit symbol stream Y (00 dash/no-op, 01 zero, 10 one, 11 end) one symbol per clock, packs data bits MSB-first into a WIDTH-bit word, and on the end symbol presents the word on a Valid/Ready output port. Malformed frames (short, long, empty, parity error) are flagged rather than delivered.

---
 rtl/barcode_word_assembler_if.sv | 12 +
 rtl/barcode_word_assembler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/barcode_word_assembler_if.sv
// Symbol-in / word-out bundle between the barcode reader, the word assembler and its consumer.
interface barcode_word_assembler_if #(parameter int WIDTH = 8);
   logic [1:0]       Y;
   logic             Ready;
   logic [WIDTH-1:0] Word;
   logic             Valid;
   logic             Err;
   logic             Ovr;

   modport master (output Y, Ready, input Word, Valid, Err, Ovr);
   modport slave  (input Y, Ready, output Word, Valid, Err, Ovr);
endinterface

// File: rtl/barcode_word_assembler.sv
// Packs barcode symbols MSB-first into WIDTH-bit words behind a Valid/Ready port.
// Define BARCODE_PARITY_EN to expect a trailing even-parity bit on every frame.
module barcode_word_assembler #(
   parameter int WIDTH = 8
) (
   input  logic                     Clk,
   input  logic                     Rst,
   barcode_word_assembler_if.slave  bus
);
`ifdef BARCODE_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int            CW       = $clog2(N + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(N);

   typedef enum logic [1:0] {IDLE, COLLECT, OVERFLOW} state_t;

   state_t           state, state_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [N-1:0]     sh, sh_d;
   logic [WIDTH-1:0] word, word_d;
   logic             valid, valid_d;
   logic             err, err_d;
   logic             ovr, ovr_d;

   logic             is_bit, is_end, bitv;
   logic             checks_ok, frame_ok, frame_bad;
   logic [WIDTH-1:0] data;

   assign is_bit = bus.Y[1] ^ bus.Y[0];
   assign is_end = &bus.Y;
   assign bitv   = bus.Y[1];
   // Data bits sit at the top of Sh; with parity the last received bit is sh[0].
   assign data   = sh[N-1 -: WIDTH];
`ifdef BARCODE_PARITY_EN
   assign checks_ok = ((^data) == sh[0]);
`else
   assign checks_ok = 1'b1;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         cnt   <= '0;
         sh    <= '0;
         word  <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         sh    <= sh_d;
         word  <= word_d;
         valid <= valid_d;
         err   <= err_d;
         ovr   <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      sh_d      = sh;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      case (state)
         IDLE: begin
            if (is_bit) begin
               sh_d    = {sh[N-2:0], bitv};
               cnt_d   = CW'(1);
               state_d = COLLECT;
            end else if (is_end) begin
               frame_bad = 1'b1;
            end
         end
         COLLECT: begin
            if (is_bit) begin
               if (cnt == CNT_FULL) begin
                  state_d = OVERFLOW;
               end else begin
                  sh_d  = {sh[N-2:0], bitv};
                  cnt_d = cnt + 1'b1;
               end
            end else if (is_end) begin
               frame_ok  = (cnt == CNT_FULL) && checks_ok;
               frame_bad = !((cnt == CNT_FULL) && checks_ok);
               state_d   = IDLE;
               cnt_d     = '0;
            end
         end
         OVERFLOW: begin
            if (is_end) begin
               frame_bad = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A good frame lands only if the output slot is free or being drained this edge.
   always_comb begin
      word_d  = word;
      valid_d = valid;
      ovr_d   = ovr;
      err_d   = frame_bad;
      if (valid && bus.Ready)
         valid_d = 1'b0;
      if (frame_ok) begin
         if (!valid || bus.Ready) begin
            word_d  = data;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign bus.Word  = word;
   assign bus.Valid = valid;
   assign bus.Err   = err;
   assign bus.Ovr   = ovr;
endmodule
